// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: arbitrates a byte-wide RAM between an instruction-fetch port
// (I-side, always 4-byte reads) and a data port (D-side, 1/2/4-byte loads
// and stores). One transfer is in flight at a time. Multi-byte transfers are
// serialised little-endian onto the byte bus. Loads can be sign-extended.
// Stores into the IO region (addr[17:16] == 2'b11) pause while the IO buffer
// is full.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : a tie goes to the requester not granted most recently
//   undefined : a tie always goes to the D-side
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_read_i, if_addr_i      fetch request and address
//   if_data_o, if_done_o      fetched word and completion pulse
//   dm_read_i, dm_write_i     load / store request (both high = store)
//   dm_sign_i, dm_len_i       sign-extend flag, length in bytes (1/2/4)
//   dm_addr_i, dm_wdata_i     byte address and store data
//   dm_rdata_o, dm_done_o     load result and completion pulse
//   mem_din_i                 read byte, valid one cycle after its address
//   mem_dout_o, mem_a_o       write byte, byte address
//   mem_wr_o                  write strobe (1 = write, 0 = read)
//   io_buffer_full_i          IO region cannot accept a write byte
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic              dm_sign_i,
    input  logic [2:0]        dm_len_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic [31:0]       dm_rdata_o,
    output logic              dm_done_o,
    input  logic [7:0]        mem_din_i,
    output logic [7:0]        mem_dout_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_wr_o,
    input  logic              io_buffer_full_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              is_d_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        len_r;
    logic              sign_r;
    logic [31:0]       wdata_r;
    logic [2:0]        cnt_r;
    logic [31:0]       rbuf_r;
    logic              mem_wr_r;

    logic              req_d_s;
    logic              grant_d_s;
    logic [2:0]        norm_len_s;
    logic [2:0]        next_cnt_s;
    logic              stall_s;
    logic              last_byte_s;
    logic [31:0]       assembled_s;
    logic [31:0]       extended_s;

    // Byte lane k of a 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_r;

    // Remembers whether the D-side won the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_r <= 1'b0;
        end else if (state_r == IDLE && (if_read_i || req_d_s)) begin
            last_d_r <= grant_d_s;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`endif

    // Request decode, tie-break and length normalisation.
    always_comb begin
        req_d_s   = dm_read_i | dm_write_i;
        grant_d_s = 1'b0;
        if (req_d_s && if_read_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_d_s = ~last_d_r;
`else
            grant_d_s = 1'b1;
`endif
        end else begin
            grant_d_s = req_d_s;
        end
        case (dm_len_i)
            3'd1:    norm_len_s = 3'd1;
            3'd2:    norm_len_s = 3'd2;
            default: norm_len_s = 3'd4;
        endcase
    end

    // Byte counter helpers and IO back-pressure; the stall gates the strobe in the same cycle.
    always_comb begin
        next_cnt_s  = cnt_r + 3'd1;
        last_byte_s = (cnt_r == (len_r - 3'd1));
        stall_s     = (state_r == WRITE) && (mem_a_o[17:16] == 2'b11) && io_buffer_full_i;
        mem_wr_o    = mem_wr_r & ~stall_s;
    end

    // Read assembly: in READ cycle with counter c (c >= 1), mem_din_i carries byte c-1.
    always_comb begin
        assembled_s = rbuf_r;
        case (cnt_r)
            3'd1:    assembled_s[7:0]   = mem_din_i;
            3'd2:    assembled_s[15:8]  = mem_din_i;
            3'd3:    assembled_s[23:16] = mem_din_i;
            3'd4:    assembled_s[31:24] = mem_din_i;
            default: assembled_s        = rbuf_r;
        endcase
        case (len_r)
            3'd1:    extended_s = {{24{sign_r & assembled_s[7]}}, assembled_s[7:0]};
            3'd2:    extended_s = {{16{sign_r & assembled_s[15]}}, assembled_s[15:0]};
            default: extended_s = assembled_s;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (if_read_i || req_d_s) begin
                    state_s = (grant_d_s && dm_write_i) ? WRITE : READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (cnt_r == len_r) begin
                    state_s = DONE;
                end else begin
                    state_s = READ;
                end
            end
            WRITE: begin
                if (!stall_s && last_byte_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_d_r     <= 1'b0;
            addr_r     <= '0;
            len_r      <= 3'd0;
            sign_r     <= 1'b0;
            wdata_r    <= 32'd0;
            cnt_r      <= 3'd0;
            rbuf_r     <= 32'd0;
            mem_wr_r   <= 1'b0;
            mem_a_o    <= '0;
            mem_dout_o <= 8'd0;
            if_data_o  <= 32'd0;
            dm_rdata_o <= 32'd0;
            if_done_o  <= 1'b0;
            dm_done_o  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (if_read_i || req_d_s) begin
                        is_d_r <= grant_d_s;
                        cnt_r  <= 3'd0;
                        rbuf_r <= 32'd0;
                        if (grant_d_s) begin
                            addr_r  <= dm_addr_i;
                            len_r   <= norm_len_s;
                            sign_r  <= dm_sign_i;
                            wdata_r <= dm_wdata_i;
                            mem_a_o <= dm_addr_i;
                        end else begin
                            addr_r  <= if_addr_i;
                            len_r   <= 3'd4;
                            sign_r  <= 1'b0;
                            wdata_r <= 32'd0;
                            mem_a_o <= if_addr_i;
                        end
                        if (grant_d_s && dm_write_i) begin
                            mem_wr_r   <= 1'b1;
                            mem_dout_o <= dm_wdata_i[7:0];
                        end else begin
                            mem_wr_r <= 1'b0;
                        end
                    end else begin
                        mem_wr_r <= 1'b0;
                    end
                end
                READ: begin
                    rbuf_r <= assembled_s;
                    cnt_r  <= next_cnt_s;
                    if (next_cnt_s < len_r) begin
                        mem_a_o <= addr_r + ADDR_W'(next_cnt_s);
                    end else begin
                        mem_a_o <= mem_a_o;
                    end
                    if (cnt_r == len_r) begin
                        if (is_d_r) begin
                            dm_rdata_o <= extended_s;
                            dm_done_o  <= 1'b1;
                        end else begin
                            if_data_o <= extended_s;
                            if_done_o <= 1'b1;
                        end
                    end else begin
                        dm_done_o <= 1'b0;
                    end
                end
                WRITE: begin
                    if (stall_s) begin
                        cnt_r <= cnt_r;
                    end else if (last_byte_s) begin
                        mem_wr_r  <= 1'b0;
                        dm_done_o <= 1'b1;
                    end else begin
                        cnt_r      <= next_cnt_s;
                        mem_a_o    <= addr_r + ADDR_W'(next_cnt_s);
                        mem_dout_o <= byte_of(wdata_r, next_cnt_s[1:0]);
                    end
                end
                DONE: begin
                    if_done_o <= 1'b0;
                    dm_done_o <= 1'b0;
                    mem_wr_r  <= 1'b0;
                end
                default: begin
                    mem_wr_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A byte table indexed by mem_a_o[7:0]
// answers reads one cycle after the address. Inputs change on the falling
// edge; outputs are sampled on the falling edge. Cycle 0 is the IDLE cycle
// in which a request is first visible.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_read_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic        dm_sign_i;
    logic [2:0]  dm_len_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_done_o;
    logic [7:0]  mem_din_i;
    logic [7:0]  mem_dout_o;
    logic [31:0] mem_a_o;
    logic        mem_wr_o;
    logic        io_buffer_full_i;

    logic [7:0]  ram_tbl [0:255];
    logic [31:0] a_log   [0:15];
    logic        wr_log  [0:15];
    logic [7:0]  dout_log[0:15];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          stall_until;
    int          done_cyc;
    logic        done_d;
    int          bad_cnt;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_read_i        (if_read_i),
        .if_addr_i        (if_addr_i),
        .if_data_o        (if_data_o),
        .if_done_o        (if_done_o),
        .dm_read_i        (dm_read_i),
        .dm_write_i       (dm_write_i),
        .dm_sign_i        (dm_sign_i),
        .dm_len_i         (dm_len_i),
        .dm_addr_i        (dm_addr_i),
        .dm_wdata_i       (dm_wdata_i),
        .dm_rdata_o       (dm_rdata_o),
        .dm_done_o        (dm_done_o),
        .mem_din_i        (mem_din_i),
        .mem_dout_o       (mem_dout_o),
        .mem_a_o          (mem_a_o),
        .mem_wr_o         (mem_wr_o),
        .io_buffer_full_i (io_buffer_full_i)
    );

    always #5 clk = ~clk;

    // Byte RAM read port with one cycle of latency.
    always @(posedge clk) mem_din_i <= ram_tbl[mem_a_o[7:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs cycles after cycle 0 until a done pulse or the budget expires (cyc_o = -1).
    task automatic wait_done(input int budget, output int cyc_o, output logic which_d);
        cyc_o   = -1;
        which_d = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            io_buffer_full_i = (c <= stall_until);
            @(negedge clk);
            if (c < 16) begin
                a_log[c]    = mem_a_o;
                wr_log[c]   = mem_wr_o;
                dout_log[c] = mem_dout_o;
            end
            if (if_done_o || dm_done_o) begin
                cyc_o   = c;
                which_d = dm_done_o;
                break;
            end
        end
        io_buffer_full_i = 1'b0;
        stall_until      = 0;
    endtask

    task automatic drop_all();
        if_read_i  = 1'b0;
        dm_read_i  = 1'b0;
        dm_write_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram_tbl[i] = 8'h00;
        ram_tbl[8'h00] = 8'h13; ram_tbl[8'h01] = 8'h05;
        ram_tbl[8'h02] = 8'h10; ram_tbl[8'h03] = 8'h00;
        ram_tbl[8'h40] = 8'h34; ram_tbl[8'h41] = 8'h92;
        ram_tbl[8'h42] = 8'h81; ram_tbl[8'h43] = 8'hA5;

        rst = 1'b1; drop_all();
        if_addr_i = 32'd0; dm_sign_i = 1'b0; dm_len_i = 3'd0;
        dm_addr_i = 32'd0; dm_wdata_i = 32'd0; io_buffer_full_i = 1'b0;
        stall_until = 0;
        repeat (3) @(negedge clk);
        check("rst_if_data", if_data_o, 32'd0);
        check("rst_dm_rdata", dm_rdata_o, 32'd0);
        check("rst_mem_a", mem_a_o, 32'd0);
        check("rst_ctl", {28'd0, mem_wr_o, if_done_o, dm_done_o, mem_dout_o != 8'd0}, 32'd0);
        rst = 1'b0;

        // Fetch at 0x100.
        if_read_i = 1'b1; if_addr_i = 32'h100;
        wait_done(20, done_cyc, done_d);
        check("fetch_cycle", done_cyc, 32'd6);
        check("fetch_side", {31'd0, done_d}, 32'd0);
        check("fetch_data", if_data_o, 32'h00100513);
        check("fetch_addrs", {a_log[1][7:0], a_log[2][7:0], a_log[3][7:0], a_log[4][7:0]}, 32'h00010203);
        check("fetch_a1", a_log[1], 32'h100);
        check("fetch_nowr", {28'd0, wr_log[1], wr_log[2], wr_log[3], wr_log[4]}, 32'd0);
        drop_all();
        @(negedge clk);
        check("fetch_data_hold", if_data_o, 32'h00100513);

        // Signed halfword load.
        dm_read_i = 1'b1; dm_len_i = 3'd2; dm_sign_i = 1'b1; dm_addr_i = 32'h40;
        wait_done(20, done_cyc, done_d);
        check("lds_cycle", done_cyc, 32'd4);
        check("lds_side", {31'd0, done_d}, 32'd1);
        check("lds_data", dm_rdata_o, 32'hFFFF9234);
        drop_all();
        @(negedge clk);

        // Unsigned halfword load.
        dm_read_i = 1'b1; dm_len_i = 3'd2; dm_sign_i = 1'b0; dm_addr_i = 32'h40;
        wait_done(20, done_cyc, done_d);
        check("ldu_cycle", done_cyc, 32'd4);
        check("ldu_data", dm_rdata_o, 32'h00009234);
        drop_all();
        @(negedge clk);

        // Signed byte load of 0x92.
        dm_read_i = 1'b1; dm_len_i = 3'd1; dm_sign_i = 1'b1; dm_addr_i = 32'h41;
        wait_done(20, done_cyc, done_d);
        check("ldb_cycle", done_cyc, 32'd3);
        check("ldb_data", dm_rdata_o, 32'hFFFFFF92);
        drop_all();
        @(negedge clk);

        // Length 3 is treated as a 4-byte load.
        dm_read_i = 1'b1; dm_len_i = 3'd3; dm_sign_i = 1'b1; dm_addr_i = 32'h40;
        wait_done(20, done_cyc, done_d);
        check("len3_cycle", done_cyc, 32'd6);
        check("len3_data", dm_rdata_o, 32'hA5819234);
        drop_all();
        @(negedge clk);

        // Word store to 0x200.
        dm_write_i = 1'b1; dm_len_i = 3'd4; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
        wait_done(20, done_cyc, done_d);
        check("st_cycle", done_cyc, 32'd5);
        check("st_side", {31'd0, done_d}, 32'd1);
        check("st_bytes", {dout_log[1], dout_log[2], dout_log[3], dout_log[4]}, 32'hEFBEADDE);
        check("st_addr1", a_log[1], 32'h200);
        check("st_addr4", a_log[4], 32'h203);
        check("st_wr", {27'd0, wr_log[1], wr_log[2], wr_log[3], wr_log[4], wr_log[5]}, 32'h1E);
        drop_all();
        @(negedge clk);

        // Read and write together: served as a write.
        dm_read_i = 1'b1; dm_write_i = 1'b1; dm_len_i = 3'd1; dm_addr_i = 32'h210; dm_wdata_i = 32'h0000005A;
        wait_done(20, done_cyc, done_d);
        check("rw_cycle", done_cyc, 32'd2);
        check("rw_wr", {31'd0, wr_log[1]}, 32'd1);
        check("rw_byte", {24'd0, dout_log[1]}, 32'h5A);
        drop_all();
        @(negedge clk);

        // IO-region byte store with the buffer full for cycles 1..3.
        dm_write_i = 1'b1; dm_len_i = 3'd1; dm_addr_i = 32'h30000; dm_wdata_i = 32'h000000C3;
        io_buffer_full_i = 1'b1; stall_until = 3;
        wait_done(20, done_cyc, done_d);
        check("io_cycle", done_cyc, 32'd5);
        check("io_stall_wr", {28'd0, wr_log[1], wr_log[2], wr_log[3], wr_log[4]}, 32'h1);
        check("io_byte", {24'd0, dout_log[4]}, 32'hC3);
        check("io_addr", a_log[4], 32'h30000);
        drop_all();
        @(negedge clk);

        // Reset during byte 2 of a word store.
        dm_write_i = 1'b1; dm_len_i = 3'd4; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        check("rs_byte1_wr", {31'd0, mem_wr_o}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("rs_byte2_a", mem_a_o, 32'h201);
        rst = 1'b1; drop_all();
        @(posedge clk); @(negedge clk);
        check("rs_outs", {mem_a_o[23:0], mem_dout_o}, 32'd0);
        check("rs_ctl", {29'd0, mem_wr_o, if_done_o, dm_done_o}, 32'd0);
        rst = 1'b0;
        bad_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_wr_o || dm_done_o || if_done_o) bad_cnt++;
        end
        check("rs_quiet", bad_cnt, 32'd0);

        // Tie: fetch 0x100 against halfword load 0x40, both kept high after the first grant.
        if_read_i = 1'b1; if_addr_i = 32'h100;
        dm_read_i = 1'b1; dm_len_i = 3'd2; dm_sign_i = 1'b0; dm_addr_i = 32'h40;
        wait_done(20, done_cyc, done_d);
        check("tie1_side", {31'd0, done_d}, 32'd1);
        check("tie1_cycle", done_cyc, 32'd4);
        wait_done(20, done_cyc, done_d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("tie2_side", {31'd0, done_d}, 32'd0);
        check("tie2_cycle", done_cyc, 32'd7);
        check("tie2_data", if_data_o, 32'h00100513);
        if_read_i = 1'b0;
        wait_done(20, done_cyc, done_d);
        check("tie3_side", {31'd0, done_d}, 32'd1);
        check("tie3_cycle", done_cyc, 32'd5);
`else
        check("tie2_side", {31'd0, done_d}, 32'd1);
        check("tie2_cycle", done_cyc, 32'd5);
        dm_read_i = 1'b0;
        wait_done(20, done_cyc, done_d);
        check("tie3_side", {31'd0, done_d}, 32'd0);
        check("tie3_cycle", done_cyc, 32'd7);
        check("tie3_data", if_data_o, 32'h00100513);
`endif
        drop_all();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
